// File: rtl/transposer_feeder.sv
// Row sequencer feeding the always-out transposer: passes source rows through, injects
// zero drain rows after a tile-boundary timeout, and emits a LAT-aligned column sideband.
module transposer_feeder #(
  parameter int DIM           = 16,
  parameter int W             = 8,
  parameter int LAT           = 1,
  parameter int DRAIN_TIMEOUT = 8,
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int IW = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_input_0_payload_discriminant,
  input  logic [DIM*W-1:0]  in_input_0_payload_Some_0,
  output logic              in_input_0_resolver_ready,
  output logic              out_output_payload_discriminant,
  output logic [DIM*W-1:0]  out_output_payload_Some_0,
  output logic              out_col_payload_discriminant,
  output logic [CW-1:0]     out_col_payload_Some_0,
  output logic              out_col_last
);

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] idx;
    logic          last;
  } col_t;

  logic [CW-1:0] cnt;
  logic          pending;
  logic          draining;
  logic [IW-1:0] idle;
  col_t          sb_q [LAT];

  logic issue;
  logic cnt_wrap;
  logic timeout_armed;

  // Row path is purely combinational so a full tile stream runs at one row per cycle.
  always_comb begin
    in_input_0_resolver_ready       = !rst && !draining;
    out_output_payload_discriminant = !rst && (draining || in_input_0_payload_discriminant);
    out_output_payload_Some_0       = draining ? '0 : in_input_0_payload_Some_0;
    issue                           = out_output_payload_discriminant;
    cnt_wrap                        = (cnt == CW'(DIM - 1));
    // Only a completed tile sitting idle at a boundary may start a drain.
    timeout_armed = pending && (cnt == '0) && !draining && !in_input_0_payload_discriminant;
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      pending  <= 1'b0;
      draining <= 1'b0;
      idle     <= '0;
      // NOTE: sideband stages are a handful of flops, so they are cleared with the rest of
      // the state; otherwise a reset mid-drain would let stale columns surface afterwards.
      for (int i = 0; i < LAT; i++) sb_q[i] <= '0;
    end else begin
      if (issue && pending) sb_q[0] <= '{valid: 1'b1, idx: cnt, last: cnt_wrap};
      else                  sb_q[0] <= '0;
      for (int i = 1; i < LAT; i++) sb_q[i] <= sb_q[i-1];

      if (issue) begin
        if (cnt_wrap) begin
          cnt      <= '0;
          pending  <= !draining;
          draining <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (timeout_armed) begin
        if (idle == IW'(DRAIN_TIMEOUT - 1)) begin
          draining <= 1'b1;
          idle     <= '0;
        end else begin
          idle <= idle + 1'b1;
        end
      end else begin
        idle <= '0;
      end
    end
  end

  always_comb begin
    out_col_payload_discriminant = sb_q[LAT-1].valid;
    out_col_payload_Some_0       = sb_q[LAT-1].idx;
    out_col_last                 = sb_q[LAT-1].last;
  end

endmodule
